// File: rtl/ir_word_encoder.sv
//==============================================================================
// Module      : ir_word_encoder
// Description : Packs instruction fields (opcode, Ra, Rb, Rc, constant) into a
//               32-bit instruction word. It range-checks the constant and
//               writes each word to instruction memory at an auto-incrementing
//               address through a write/acknowledge handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ir_word_encoder #(
    parameter int AW = 9
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    fmt,
    input  logic [4:0]    opcode,
    input  logic [3:0]    ra,
    input  logic [3:0]    rb,
    input  logic [3:0]    rc,
    input  logic [31:0]   const_in,
    input  logic          addr_load,
    input  logic [AW-1:0] addr_in,
    output logic          mem_wr,
    input  logic          mem_ack,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data,
    output logic          err_range,
    output logic          wrap,
    output logic [15:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t          state_q;
    logic [1:0]      fmt_q;
    logic [4:0]      opcode_q;
    logic [3:0]      ra_q;
    logic [3:0]      rb_q;
    logic [3:0]      rc_q;
    logic [31:0]     const_q;
    logic            mem_wr_q;
    logic [AW-1:0]   mem_addr_q;
    logic [31:0]     mem_data_q;
    logic            err_range_q;
    logic            wrap_q;
    logic [15:0]     word_count_q;

    logic [31:0]     mem_data_d;
    logic            range_bad;

    // The block takes a field set only in IDLE, and an address load pre-empts it.
    assign in_ready = clear & (state_q == S_IDLE) & ~addr_load;

    // Pack the captured fields and flag a constant that does not fit in 19 bits.
    always_comb begin
        mem_data_d = 32'd0;
        range_bad  = 1'b0;
        case (fmt_q)
            2'd0:    mem_data_d = {opcode_q, ra_q, rb_q, rc_q, 15'd0};
            2'd1:    mem_data_d = {opcode_q, ra_q, rb_q, const_q[18:0]};
            2'd2:    mem_data_d = {opcode_q, ra_q, 4'd0, const_q[18:0]};
            default: mem_data_d = {opcode_q, 27'd0};
        endcase
        if ((fmt_q == 2'd1) || (fmt_q == 2'd2)) begin
            range_bad = (const_q[31:18] != {14{const_q[18]}});
        end
    end

    // Capture -> check -> write sequencing, address counter and status flags.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q      <= S_IDLE;
            fmt_q        <= 2'd0;
            opcode_q     <= 5'd0;
            ra_q         <= 4'd0;
            rb_q         <= 4'd0;
            rc_q         <= 4'd0;
            const_q      <= 32'd0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= 32'd0;
            err_range_q  <= 1'b0;
            wrap_q       <= 1'b0;
            word_count_q <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (addr_load) begin
                        mem_addr_q <= addr_in;
                    end else if (in_valid) begin
                        fmt_q    <= fmt;
                        opcode_q <= opcode;
                        ra_q     <= ra;
                        rb_q     <= rb;
                        rc_q     <= rc;
                        const_q  <= const_in;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (range_bad) begin
                        // Rejected words are dropped without touching the address.
                        err_range_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        mem_data_q <= mem_data_d;
                        mem_wr_q   <= 1'b1;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= mem_addr_q + ADDR_ONE;
                        if (&mem_addr_q) begin
                            wrap_q <= 1'b1;
                        end
                        if (word_count_q != 16'hFFFF) begin
                            word_count_q <= word_count_q + 16'd1;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign err_range  = err_range_q;
    assign wrap       = wrap_q;
    assign word_count = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ir_word_encoder.sv
//==============================================================================
// Module      : tb_ir_word_encoder
// Description : Scoreboard bench for ir_word_encoder. Expected writes are
//               queued when a field set is accepted and compared when the DUT
//               completes the memory handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ir_word_encoder;

    localparam int AW = 9;

    logic          clock;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    fmt;
    logic [4:0]    opcode;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic [3:0]    rc;
    logic [31:0]   const_in;
    logic          addr_load;
    logic [AW-1:0] addr_in;
    logic          mem_wr;
    logic          mem_ack;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          err_range;
    logic          wrap;
    logic [15:0]   word_count;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t          sb[$];
    int            wr_times[$];
    int            cyc;
    int            n_checks;
    int            n_err;

    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_count;
    logic          exp_err;
    logic          exp_wrap;

    ir_word_encoder #(.AW(AW)) dut (
        .clock      (clock),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .ra         (ra),
        .rb         (rb),
        .rc         (rc),
        .const_in   (const_in),
        .addr_load  (addr_load),
        .addr_in    (addr_in),
        .mem_wr     (mem_wr),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .err_range  (err_range),
        .wrap       (wrap),
        .word_count (word_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [1:0] f, input logic [4:0] op,
                                        input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [31:0] k);
        case (f)
            2'd0:    return {op, a, b, c, 15'b0};
            2'd1:    return {op, a, b, k[18:0]};
            2'd2:    return {op, a, 4'b0, k[18:0]};
            default: return {op, 27'b0};
        endcase
    endfunction

    function automatic logic fits19(input logic [31:0] k);
        return (k[31:18] == 14'h0000) || (k[31:18] == 14'h3FFF);
    endfunction

    // Write monitor: a handshake completing at the next edge must match the queue head.
    always @(negedge clock) begin
        if (clear && mem_wr && mem_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {23'd0, mem_addr}, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_addr", {23'd0, mem_addr}, {23'd0, e.addr});
                check("sb_data", mem_data, e.data);
                wr_times.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_addr(input logic [AW-1:0] a);
        addr_load = 1'b1;
        addr_in   = a;
        @(negedge clock);
        check("load_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        addr_load = 1'b0;
        exp_addr  = a;
    endtask

    // Present a field set and hold it until accepted; returns one step after the accept edge.
    task automatic send(input logic [1:0] f, input logic [4:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c, input logic [31:0] k);
        bit got;
        exp_t e;
        got      = 1'b0;
        fmt      = f;
        opcode   = op;
        ra       = a;
        rb       = b;
        rc       = c;
        const_in = k;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clock);
            if ((f == 2'd1 || f == 2'd2) && !fits19(k)) begin
                exp_err = 1'b1;
            end else begin
                e.addr = exp_addr;
                e.data = enc(f, op, a, b, c, k);
                sb.push_back(e);
                if (exp_addr == {AW{1'b1}}) exp_wrap = 1'b1;
                exp_addr = exp_addr + 1'b1;
                if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            end
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !mem_wr && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic wait_wr();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_wr) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wr_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_addr"},  {23'd0, mem_addr},   {23'd0, exp_addr});
        check({tag, "_count"}, {16'd0, word_count}, {16'd0, exp_count});
        check({tag, "_err"},   {31'd0, err_range},  {31'd0, exp_err});
        check({tag, "_wrap"},  {31'd0, wrap},       {31'd0, exp_wrap});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_mem_wr"},   {31'd0, mem_wr},   32'd0);
        check({tag, "_addr"},     {23'd0, mem_addr}, 32'd0);
        check({tag, "_data"},     mem_data,          32'd0);
        check({tag, "_err"},      {31'd0, err_range}, 32'd0);
        check({tag, "_wrap"},     {31'd0, wrap},     32'd0);
        check({tag, "_count"},    {16'd0, word_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] s_addr;
        logic [31:0]   s_data;
        cyc       = 0;
        n_checks  = 0;
        n_err     = 0;
        exp_addr  = '0;
        exp_count = 16'd0;
        exp_err   = 1'b0;
        exp_wrap  = 1'b0;
        clear     = 1'b1;
        in_valid  = 1'b0;
        fmt       = 2'd0;
        opcode    = 5'd0;
        ra        = 4'd0;
        rb        = 4'd0;
        rc        = 4'd0;
        const_in  = 32'd0;
        addr_load = 1'b0;
        addr_in   = '0;
        mem_ack   = 1'b0;

        // Reset state
        #1 clear = 1'b0;
        #2;
        check_reset_values("reset");
        repeat (2) @(posedge clock);
        #1 clear = 1'b1;

        // Address load and fmt1 encode, ack withheld to observe timing
        load_addr(9'h010);
        @(negedge clock);
        check("load_addr", {23'd0, mem_addr}, 32'h010);
        step();
        send(2'd1, 5'b00011, 4'd2, 4'd3, 4'd0, 32'hFFFFFFFB);
        @(negedge clock);
        check("n1_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("n1_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        check("n2_mem_wr", {31'd0, mem_wr}, 32'd1);
        check("n2_addr", {23'd0, mem_addr}, 32'h010);
        check("n2_data", mem_data, 32'h191FFFFB);
        step();
        mem_ack = 1'b1;
        wait_idle();
        check("t1_addr", {23'd0, mem_addr}, 32'h011);
        check("t1_count", {16'd0, word_count}, 32'd1);

        // Back-to-back fmt0 and fmt3 with ack tied high
        wr_times.delete();
        send(2'd0, 5'b00100, 4'd1, 4'd2, 4'd3, 32'hFFFFFFFF);
        send(2'd3, 5'b11010, 4'd7, 4'd8, 4'd9, 32'h12345678);
        wait_idle();
        check("b2b_writes", wr_times.size(), 32'd2);
        if (wr_times.size() == 2) check("b2b_spacing", wr_times[1] - wr_times[0], 32'd3);
        check("enc_fmt0", enc(2'd0, 5'b00100, 4'd1, 4'd2, 4'd3, 32'hFFFFFFFF), 32'h20918000);
        check("enc_fmt3", enc(2'd3, 5'b11010, 4'd7, 4'd8, 4'd9, 32'h12345678), 32'hD0000000);
        check_status("b2b");

        // Range error, then minimum constant accepted
        send(2'd1, 5'b00111, 4'd4, 4'd5, 4'd0, 32'h00040000);
        @(negedge clock);
        check("rej_n1_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        @(negedge clock);
        check("rej_n2_in_ready", {31'd0, in_ready}, 32'd1);
        check("rej_err", {31'd0, err_range}, 32'd1);
        check("rej_mem_wr", {31'd0, mem_wr}, 32'd0);
        step();
        check_status("rej");
        send(2'd2, 5'b00001, 4'd5, 4'd0, 4'd0, 32'hFFFC0000);
        wait_idle();
        check_status("minconst");

        // Ack stall
        mem_ack = 1'b0;
        send(2'd0, 5'b01010, 4'd9, 4'd10, 4'd11, 32'd0);
        wait_wr();
        s_addr = mem_addr;
        s_data = mem_data;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("stall_wr", {31'd0, mem_wr}, 32'd1);
            check("stall_addr", {23'd0, mem_addr}, {23'd0, s_addr});
            check("stall_data", mem_data, s_data);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        wait_idle();
        check_status("stall");

        // Wrap
        mem_ack = 1'b1;
        load_addr(9'h1FF);
        send(2'd3, 5'b10101, 4'd0, 4'd0, 4'd0, 32'd0);
        wait_idle();
        check("wrap_addr", {23'd0, mem_addr}, 32'h000);
        check("wrap_flag", {31'd0, wrap}, 32'd1);
        check_status("wrap");

        // Load priority over a simultaneous field set
        addr_load = 1'b1;
        addr_in   = 9'h055;
        in_valid  = 1'b1;
        fmt       = 2'd0;
        opcode    = 5'b11111;
        @(negedge clock);
        check("prio_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        addr_load = 1'b0;
        in_valid  = 1'b0;
        exp_addr  = 9'h055;
        repeat (3) @(negedge clock);
        check("prio_mem_wr", {31'd0, mem_wr}, 32'd0);
        step();
        check_status("prio");

        // Reset mid-WRITE discards the pending word
        mem_ack = 1'b0;
        send(2'd1, 5'b00010, 4'd1, 4'd1, 4'd0, 32'd100);
        wait_wr();
        #3 clear = 1'b0;
        #1;
        sb.delete();
        exp_addr  = '0;
        exp_count = 16'd0;
        exp_err   = 1'b0;
        exp_wrap  = 1'b0;
        check_reset_values("midrst");
        step();
        clear   = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("post_rst_wr", {31'd0, mem_wr}, 32'd0);
        end
        step();
        check_status("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ir_word_encoder.md
# ir_word_encoder

Instruction-word encoder: the inverse of the IR field select/decode logic. Accepts instruction fields (opcode, Ra, Rb, Rc, constant) from a host or loader through a valid/ready handshake and packs them into the 32-bit instruction format. Range-checks the constant and writes each word to instruction memory at an auto-incrementing address through a write/acknowledge handshake. Sits between the test/program loader and the memory write port; it is used to fill memory before the CPU is released from reset.

## Interface
- AW, 9, memory address width (512-word memory)
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous active-low reset
- in_valid  in  1  field set presented
- in_ready  out  1  block can accept a field set this cycle
- fmt  in  2  format: 0 = three-register, 1 = two-register + constant, 2 = one-register + constant, 3 = opcode only
- opcode  in  5  instruction bits 31:27
- ra, rb, rc  in  4 each  register indices
- const_in  in  32  signed constant (two's complement)
- addr_load  in  1  load base address (honoured only in IDLE)
- addr_in  in  AW  base address value
- mem_wr  out  1  write request
- mem_ack  in  1  memory accepted the write
- mem_addr  out  AW  write address
- mem_data  out  32  encoded instruction word
- err_range  out  1  sticky: a constant did not fit in 19 bits
- wrap  out  1  sticky: address counter wrapped
- word_count  out  16  words written, saturating at 16'hFFFF

## Operation
- Packing, with unused fields zero:
  - fmt0: {opcode, ra, rb, rc, 15'b0}
  - fmt1: {opcode, ra, rb, const_in[18:0]}
  - fmt2: {opcode, ra, 4'b0, const_in[18:0]}
  - fmt3: {opcode, 27'b0}
- const_in is ignored for fmt0 and fmt3. For fmt1 and fmt2 it must lie in [-262144, 262143], i.e. bits 31:18 must all equal bit 18.
- FSM states IDLE, CHECK, WRITE:
  - IDLE: in_ready = ~addr_load. If addr_load is high, mem_addr <= addr_in. On in_valid & in_ready, capture all fields; go to CHECK.
  - CHECK: in_ready = 0. If the constant is out of range, set err_range, drop the word, leave the address unchanged, and return to IDLE. Otherwise register mem_data and go to WRITE.
  - WRITE: mem_wr = 1. mem_addr and mem_data hold stable. On mem_ack: mem_addr <= mem_addr + 1 mod 2^AW, word_count increments (saturating), go to IDLE. If the old address was all ones, set wrap.
- addr_load outside IDLE is ignored. addr_load together with in_valid in IDLE: the load wins and the field set is not accepted that cycle (in_ready = 0).
- mem_ack outside WRITE is ignored.
- err_range and wrap clear only on reset.

## Timing
- All outputs are registered, except in_ready, which is decoded from state and addr_load.
- Reset values: state IDLE, mem_wr 0, mem_addr 0, mem_data 0, err_range 0, wrap 0, word_count 0. in_ready is 0 while clear is asserted.
- Accept at edge N. CHECK during cycle N+1. mem_wr and mem_data are valid from cycle N+2. mem_ack is sampled at the edge.
- With mem_ack tied high, peak throughput is one word per 3 cycles. in_ready rises the cycle after the acknowledging edge.
- A rejected (out-of-range) word returns to IDLE at edge N+1; in_ready is high again in cycle N+2.
- clear mid-CHECK or mid-WRITE: outputs go to reset values immediately and the pending word is discarded; it must not be written after release.

## Test plan
- Address and fmt1 encode: addr_load with 0x010, then fmt1 with opcode 5'b00011, ra 2, rb 3, const_in -5.
  - Required: in cycle N+2, mem_wr 1, mem_addr 0x010, mem_data 0x191FFFFB.
  - After ack: mem_addr 0x011, word_count 1.
- fmt0 and fmt3 encode, back-to-back, with mem_ack tied high:
  - fmt0 with opcode 5'b00100, ra 1, rb 2, rc 3, const_in 0xFFFFFFFF gives mem_data 0x20918000.
  - fmt3 with opcode 5'b11010 gives 0xD0000000.
  - The second word is written 3 cycles after the first.
- Range error:
  - fmt1 with const_in 0x00040000 gives err_range 1, no mem_wr, mem_addr and word_count unchanged.
  - A following fmt2 with const_in 0xFFFC0000 (minimum value) is written normally, and err_range stays 1.
- Ack stall: hold mem_ack low 4 cycles in WRITE. mem_wr, mem_addr and mem_data must stay stable, and in_ready must stay 0. Pulse mem_ack; exactly one increment follows.
- Wrap and load priority:
  - addr_load 0x1FF and write one word: the word goes to 0x1FF, then mem_addr becomes 0x000 and wrap becomes 1.
  - addr_load together with in_valid: in_ready is 0 and no capture happens that cycle.
- Reset mid-WRITE: assert clear while mem_wr is 1.
  - mem_wr drops asynchronously, all outputs take reset values, and after release no write occurs without new input.
